wide_compare_seq: RTL and testbench



---
 rtl/wide_compare_seq.sv | 117 +++++++++++
 tb/tb_wide_compare_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/wide_compare_seq.sv
// Sequencer that walks two NUM_WORDS x 32-bit operands through a shared 32-bit
// equality comparator, least-significant word first, stopping at the first mismatch.
module wide_compare_seq #(
  parameter int NUM_WORDS = 4,
  parameter int IDX_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [32*NUM_WORDS-1:0] op_a,
  input  logic [32*NUM_WORDS-1:0] op_b,
  output logic                    busy,
  output logic                    done,
  output logic                    eq_out,
  output logic [IDX_W-1:0]        mismatch_idx,
  output logic [31:0]             cmp_a,
  output logic [31:0]             cmp_b,
  input  logic                    cmp_eq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [IDX_W-1:0]        idx_r;
  logic [IDX_W-1:0]        idx_inc_s;
  logic                    last_s;
  logic [32*NUM_WORDS-1:0] a_r;
  logic [32*NUM_WORDS-1:0] b_r;

  assign idx_inc_s = idx_r + IDX_W'(1);
  assign last_s    = (idx_r == IDX_W'(NUM_WORDS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: early exit on first unequal word, otherwise run to the last word
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_CMP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CMP: begin
        if (!cmp_eq || last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_CMP;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Operand latch, word pointer, comparator drive and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r          <= '0;
      b_r          <= '0;
      idx_r        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      eq_out       <= 1'b0;
      mismatch_idx <= '0;
      cmp_a        <= 32'd0;
      cmp_b        <= 32'd0;
    end else begin
      busy <= (state_s == ST_CMP);
      done <= (state_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_r          <= op_a;
            b_r          <= op_b;
            idx_r        <= '0;
            eq_out       <= 1'b0;
            mismatch_idx <= '0;
            // Word 0 is loaded here so the comparator sees it in the first CMP cycle
            cmp_a        <= op_a[31:0];
            cmp_b        <= op_b[31:0];
          end
        end
        ST_CMP: begin
          if (!cmp_eq) begin
            eq_out       <= 1'b0;
            mismatch_idx <= idx_r;
          end else if (last_s) begin
            eq_out       <= 1'b1;
            mismatch_idx <= '0;
          end else begin
            idx_r <= idx_inc_s;
            cmp_a <= a_r[32*idx_inc_s +: 32];
            cmp_b <= b_r[32*idx_inc_s +: 32];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wide_compare_seq.sv
// Scoreboard bench for wide_compare_seq: the driver pushes expected comparator words
// and results; a negedge monitor pops and checks them whenever busy/done is seen.
module tb_wide_compare_seq;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] op_a;
  logic [127:0] op_b;
  logic         busy;
  logic         done;
  logic         eq_out;
  logic [3:0]   mismatch_idx;
  logic [31:0]  cmp_a;
  logic [31:0]  cmp_b;
  logic         cmp_eq;

  typedef struct {
    logic       eq;
    logic [3:0] midx;
    int         edge_n;
  } done_t;

  done_t       dq[$];
  logic [63:0] cq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          ecnt  = 0;

  wide_compare_seq #(.NUM_WORDS(4), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .eq_out(eq_out), .mismatch_idx(mismatch_idx),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_eq(cmp_eq)
  );

  // Stand-in for the external 32-bit equality comparator
  assign cmp_eq = (cmp_a == cmp_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    done_t       e;
    logic [63:0] w;
    if (done) begin
      if (dq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_done: got done=1 expected no result (edge %0d)", ecnt);
      end else begin
        e = dq.pop_front();
        chk("eq_out", 64'(eq_out), 64'(e.eq));
        chk("mismatch_idx", 64'(mismatch_idx), 64'(e.midx));
        chk("done_cycle", 64'(ecnt), 64'(e.edge_n));
      end
    end
    if (busy) begin
      if (cq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_busy: got busy=1 expected idle (edge %0d)", ecnt);
      end else begin
        w = cq.pop_front();
        chk("cmp_a", 64'(cmp_a), 64'(w[63:32]));
        chk("cmp_b", 64'(cmp_b), 64'(w[31:0]));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_done"}, 64'(done), 64'd0);
    chk({name, "_eq"}, 64'(eq_out), 64'd0);
    chk({name, "_midx"}, 64'(mismatch_idx), 64'd0);
    chk({name, "_cmp_a"}, 64'(cmp_a), 64'd0);
    chk({name, "_cmp_b"}, 64'(cmp_b), 64'd0);
  endtask

  // Issue a start this cycle; k = number of CMP cycles expected
  task automatic issue(input logic [127:0] a, input logic [127:0] b, input int k,
                       input logic eq, input logic [3:0] midx, input bit exp_done);
    done_t e;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    if (exp_done) begin
      e.eq     = eq;
      e.midx   = midx;
      e.edge_n = ecnt + 1 + k;
      dq.push_back(e);
    end
    for (int i = 0; i < k; i++) begin
      cq.push_back({a[32*i +: 32], b[32*i +: 32]});
    end
    step();
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20; i++) begin
      if (dq.size() == 0 && !busy && !done) break;
      step();
    end
    chk({name, "_drain"}, 64'(dq.size()), 64'd0);
  endtask

  localparam logic [127:0] V = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;

    // Reset then idle
    step(); check_idle("reset1");
    step(); check_idle("reset2");
    rst = 1'b0;
    step(); check_idle("idle");

    // All four words equal
    issue(V, V, 4, 1'b1, 4'd0, 1'b1);
    drain("full_equal");
    chk("full_equal_hold_eq", 64'(eq_out), 64'd1);

    // Mismatch in word 1
    issue(128'h0123_4567_89AB_CDEF_0000_0000_7654_3210,
          128'h0123_4567_89AB_CDEF_0000_0001_7654_3210, 2, 1'b0, 4'd1, 1'b1);
    drain("early_mismatch");
    chk("early_hold_midx", 64'(mismatch_idx), 64'd1);
    chk("early_hold_eq", 64'(eq_out), 64'd0);

    // Only bit 127 differs
    issue(V, V ^ {1'b1, 127'd0}, 4, 1'b0, 4'd3, 1'b1);
    drain("last_word");

    // start re-pulsed and op_b altered mid-compare; start during DONE ignored
    issue(128'hDEAD_BEEF_CAFE_F00D_1234_5678_A5A5_5A5A,
          128'hDEAD_BEEF_CAFE_F00D_1234_5678_A5A5_5A5A, 4, 1'b1, 4'd0, 1'b1);
    step();
    start = 1'b1;
    op_b  = ~op_b;
    step();
    start = 1'b0;
    step();
    step();
    start = 1'b1;
    op_a  = 128'h1111_1111_2222_2222_3333_3333_4444_4444;
    op_b  = 128'h1111_1111_2222_2223_3333_3333_4444_4444;
    step();
    chk("hold6_eq", 64'(eq_out), 64'd1);
    chk("hold6_midx", 64'(mismatch_idx), 64'd0);
    chk("hold6_busy", 64'(busy), 64'd0);
    issue(128'h1111_1111_2222_2222_3333_3333_4444_4444,
          128'h1111_1111_2222_2223_3333_3333_4444_4444, 3, 1'b0, 4'd2, 1'b1);
    drain("restart");

    // Reset in cycle 2 of a compare
    issue(V, V, 2, 1'b1, 4'd0, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("mid_reset");
    for (int i = 0; i < 6; i++) step();
    issue(V, V ^ 128'd1, 1, 1'b0, 4'd0, 1'b1);
    drain("after_reset");

    step();
    chk("done_queue_empty", 64'(dq.size()), 64'd0);
    chk("cmp_queue_empty", 64'(cq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
